// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: reads PC, fetches one word over a req/ack
// handshake, then strobes the IR and PC+4 into their registers.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_write,
    output logic [31:0] ir_wdata,
    output logic        pc_write,
    output logic [31:0] pc_wdata,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      addr_nxt, ir_nxt, pc_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = mem_addr;
        ir_nxt    = ir_wdata;
        pc_nxt    = pc_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt = pc_in;
                    if (pc_in[1:0] == 2'b00) begin
                        state_nxt = REQ;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    ir_nxt    = mem_rdata;
                    pc_nxt    = mem_addr + 32'd4;
                    state_nxt = DONE;
                end else begin
                    // Counter value k means k REQ cycles have already gone unanswered.
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ERR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each state's strobes are
    // visible for exactly the cycle spent in it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_addr <= RESET_PC;
            ir_wdata <= '0;
            pc_wdata <= '0;
            mem_req  <= 1'b0;
            ir_write <= 1'b0;
            pc_write <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_addr <= addr_nxt;
            ir_wdata <= ir_nxt;
            pc_wdata <= pc_nxt;
            mem_req  <= (state_nxt == REQ);
            ir_write <= (state_nxt == DONE);
            pc_write <= (state_nxt == DONE);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE) || (state_nxt == ERR);
            fault    <= (state_nxt == ERR);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences
// and randomized fetches checked against a transaction-level model.
module tb_fetch_unit;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_write;
    logic [31:0] ir_wdata;
    logic        pc_write;
    logic [31:0] pc_wdata;
    logic        busy;
    logic        done;
    logic        fault;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir_write(ir_write), .ir_wdata(ir_wdata),
        .pc_write(pc_write), .pc_wdata(pc_wdata), .busy(busy),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          wait_n;
        logic [31:0] data;
        bit          noise;
        int          lat;
        bit          flt;
        bit          wr;
        logic [31:0] pcdat;
        int          reqs;
    } vec_t;

    typedef struct {
        int          lat;
        bit          flt;
        bit          irw;
        bit          pcw;
        logic [31:0] irdat;
        logic [31:0] pcdat;
        int          reqs;
        bit          stable;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues one start in the current (IDLE) cycle and plays memory with
    // `wait_n` no-ack REQ cycles before acking. Returns in the done cycle.
    task automatic fetch(input logic [31:0] pc, input int wait_n, input logic [31:0] data,
                         input bit noise, output obs_t o);
        o = '{lat: 0, flt: 0, irw: 0, pcw: 0, irdat: '0, pcdat: '0, reqs: 0, stable: 1};
        start   = 1'b1;
        pc_in   = pc;
        mem_ack = 1'b0;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            o.lat++;
            if (done) begin
                o.flt   = fault;
                o.irw   = ir_write;
                o.pcw   = pc_write;
                o.irdat = ir_wdata;
                o.pcdat = pc_wdata;
                mem_ack = 1'b0;
                start   = 1'b0;
                return;
            end
            if (mem_req) begin
                o.reqs++;
                if (mem_addr !== pc) o.stable = 0;
            end
            if (mem_req && (o.reqs - 1) == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = data;
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0) && !mem_req;
                mem_rdata = $urandom;
            end
            if (noise) begin
                start = $urandom_range(0, 1) == 1;
                pc_in = $urandom;
            end
            cyc();
        end
        chk("done_within_bound", 32'd0, 32'd1);
        mem_ack = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input vec_t v);
        chk({tag, "_latency"}, o.lat, v.lat);
        chk({tag, "_fault"}, {31'd0, o.flt}, {31'd0, v.flt});
        chk({tag, "_ir_write"}, {31'd0, o.irw}, {31'd0, v.wr});
        chk({tag, "_pc_write"}, {31'd0, o.pcw}, {31'd0, v.wr});
        chk({tag, "_req_cycles"}, o.reqs, v.reqs);
        chk({tag, "_addr_stable"}, {31'd0, o.stable}, 32'd1);
        if (v.wr) begin
            chk({tag, "_ir_wdata"}, o.irdat, v.data);
            chk({tag, "_pc_wdata"}, o.pcdat, v.pcdat);
        end
    endtask

    vec_t vecs[7];
    obs_t obs;
    vec_t ref_v;
    int   writes;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0040_0000, 0,  32'h2008_0005, 0, 2,  0, 1, 32'h0040_0004, 1};
        vecs[1] = '{32'h0040_0010, 3,  32'h8C01_0000, 1, 5,  0, 1, 32'h0040_0014, 4};
        vecs[2] = '{32'h0040_0002, 0,  32'h0,         0, 1,  1, 0, 32'h0,         0};
        vecs[3] = '{32'h0040_0004, 99, 32'h0,         1, 17, 1, 0, 32'h0,         16};
        vecs[4] = '{32'hFFFF_FFFC, 0,  32'h1234_5678, 0, 2,  0, 1, 32'h0000_0000, 1};
        vecs[5] = '{32'h0040_0008, 15, 32'hDEAD_BEEF, 0, 17, 0, 1, 32'h0040_000C, 16};
        vecs[6] = '{32'h0040_0003, 0,  32'h0,         1, 1,  1, 0, 32'h0,         0};

        rst = 1'b0; start = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset held: start must be ignored.
        start = 1'b1; pc_in = 32'h0040_0010;
        cyc(); cyc(); cyc();
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        cyc();
        chk("post_rst_strobes", {27'd0, mem_req, ir_write, pc_write, done, fault}, 32'd0);
        chk("post_rst_data", ir_wdata | pc_wdata, 32'd0);

        for (int i = 0; i < 7; i++) begin
            fetch(vecs[i].pc, vecs[i].wait_n, vecs[i].data, vecs[i].noise, obs);
            check_obs($sformatf("vec%0d", i), obs, vecs[i]);
            cyc();
            chk($sformatf("vec%0d_idle", i), {30'd0, busy, done}, 32'd0);
        end

        // start coincident with done is dropped.
        fetch(32'h0040_0100, 0, 32'h0000_0001, 0, obs);
        start = 1'b1; pc_in = 32'h0040_0200;
        cyc();
        start = 1'b0;
        cyc();
        chk("start_on_done_dropped", {30'd0, busy, mem_req}, 32'd0);

        // Reset during REQ clears outputs without waiting for a clock edge.
        start = 1'b1; pc_in = 32'h0040_0020;
        cyc();
        start = 1'b0;
        chk("midrst_in_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req_async", {31'd0, mem_req}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_addr", mem_addr, RESET_PC);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        cyc();
        rst = 1'b1;
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (ir_write || pc_write || mem_req) writes++;
        end
        mem_ack = 1'b0;
        chk("midrst_no_writes", writes, 0);

        // Randomized fetches against a transaction-level model.
        for (int i = 0; i < 30; i++) begin
            ref_v.pc     = $urandom;
            ref_v.pc[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ref_v.wait_n = $urandom_range(0, 20);
            ref_v.data   = $urandom;
            ref_v.noise  = $urandom_range(0, 1) == 1;
            if (ref_v.pc[1:0] != 2'b00) begin
                ref_v.lat = 1; ref_v.flt = 1; ref_v.wr = 0; ref_v.reqs = 0;
            end else if (ref_v.wait_n < TIMEOUT) begin
                ref_v.lat = ref_v.wait_n + 2; ref_v.flt = 0; ref_v.wr = 1;
                ref_v.reqs = ref_v.wait_n + 1;
            end else begin
                ref_v.lat = TIMEOUT + 1; ref_v.flt = 1; ref_v.wr = 0; ref_v.reqs = TIMEOUT;
            end
            ref_v.pcdat = ref_v.pc + 32'd4;
            fetch(ref_v.pc, ref_v.wait_n, ref_v.data, ref_v.noise, obs);
            check_obs($sformatf("rnd%0d", i), obs, ref_v);
            cyc();
            chk($sformatf("rnd%0d_idle", i), {30'd0, busy, done}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch sequencer for the multicycle, non-pipelined CPU. It sits between the PC register and the instruction register. On a start pulse from the main controller it reads the PC value and issues a word read to instruction memory with a req/ack handshake. It then writes the fetched word into the IR and PC+4 back into the PC register, using those registers' write strobes. It also flags misaligned PCs and memory timeouts.

Parameters:
RESET_PC, 32'h0040_0000, reset value of the internal address latch and of mem_addr
TIMEOUT, 16, maximum number of REQ cycles without mem_ack before a fault is raised (must be >= 1)
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
start  input  1  single-cycle fetch request from the controller; ignored while busy=1
pc_in  input  32  current PC (the PC register's read data); sampled only on an accepted start
mem_req  output  1  instruction-memory read request
mem_addr  output  32  word address for instruction memory
mem_ack  input  1  memory has valid data on mem_rdata this cycle
mem_rdata  input  32  instruction word from memory
ir_write  output  1  write strobe to the instruction register
ir_wdata  output  32  instruction word for the IR
pc_write  output  1  write strobe to the PC register
pc_wdata  output  32  next PC = fetched address + 4
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse marking the end of a fetch, successful or faulted
fault  output  1  one-cycle pulse, coincident with done, on a misaligned PC or a timeout

Behaviour:
- All outputs are registered. There are no combinational paths from input to output.
- Reset (rst=0, asynchronous):
  - state goes to IDLE; mem_req, ir_write, pc_write, busy, done and fault go to 0;
  - mem_addr goes to RESET_PC; ir_wdata, pc_wdata and the timeout counter go to 0.
  - Reset asserted mid-operation abandons the fetch at once. No IR or PC write occurs.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - start=1 latches pc_in into mem_addr.
  - If pc_in[1:0]==2'b00, go to REQ. Otherwise go to ERR; mem_req is never raised.
- REQ:
  - mem_req=1, busy=1, and mem_addr is held stable.
  - mem_ack is sampled every REQ cycle, including the first.
  - On mem_ack=1: capture mem_rdata into ir_wdata, set pc_wdata = mem_addr + 32'd4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000), go to DONE. mem_req falls the next cycle.
  - On mem_ack=0: increment the counter. When the counter reaches TIMEOUT, go to ERR.
- DONE, exactly one cycle:
  - ir_write=1, pc_write=1, done=1, busy=1; then go to IDLE.
- ERR, exactly one cycle:
  - done=1, fault=1, busy=1, ir_write=0, pc_write=0; then go to IDLE.
- The counter clears on entry to REQ.
- Latency with zero-wait memory (ack in the first REQ cycle): start at cycle N, mem_req at N+1, writes and done at N+2.
- Each extra ack wait cycle adds one cycle of latency.
- start asserted while busy=1 is dropped, not queued. start in the same cycle that done is high is also dropped.
- mem_ack outside REQ is ignored. mem_rdata is don't-care when mem_ack=0.
- A back-to-back fetch is possible: start in the first IDLE cycle after DONE is accepted.

Test Plan:
- Reset:
  - hold rst=0, pulse start;
  - expect mem_addr=32'h0040_0000, busy=0, no mem_req;
  - after rst=1, expect all strobes still 0.
- Zero-wait fetch:
  - pc_in=32'h0040_0000, start at cycle 0, mem_ack=1 with mem_rdata=32'h2008_0005 in the first REQ cycle;
  - expect at cycle 2 ir_write=1, ir_wdata=32'h2008_0005, pc_write=1, pc_wdata=32'h0040_0004, done=1, fault=0.
- Wait states:
  - pc_in=32'h0040_0010, ack delayed 3 cycles;
  - expect mem_req high for 4 cycles with mem_addr stable, then done with pc_wdata=32'h0040_0014;
  - start pulses issued during REQ are ignored.
- Misaligned PC:
  - pc_in=32'h0040_0002;
  - expect mem_req never high, done=fault=1 one cycle after start, no IR or PC write.
- Timeout and wrap:
  - no ack at all: expect fault after TIMEOUT=16 REQ cycles, no writes.
  - pc_in=32'hFFFF_FFFC with immediate ack: expect pc_wdata=32'h0000_0000.
- Reset mid-fetch:
  - drop rst during REQ;
  - expect mem_req=0 immediately (asynchronously), state IDLE, and no ir_write or pc_write pulse afterwards.
